game_flow_ctrl: RTL and testbench

Top-level game sequencer for the VGA plane game. Tracks attract, play, respawn and game-over phases and counts remaining lives and a 4-digit BCD score. Drives the `play` qualifier, invulnerability window and per-frame enable consumed by the plane, bullet, enemy and rgb blocks. Inputs are the frame strobe from the VGA driver, hit events from collision logic and the keyboard fire key.

---
 rtl/game_flow_pkg.sv | 39 +++
 rtl/game_flow_ctrl_bcd4_counter.sv | 32 +++
 rtl/game_flow_ctrl.sv | 138 +++++++++++++
 tb/tb_game_flow_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/game_flow_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | game_flow_pkg
// | Shared state encoding, BCD constants and BCD increment helper.
// | Revision: 1.0
// +-----------------------------------------------------------------------------
package game_flow_pkg;

   typedef enum logic [1:0] {
      ST_ATTRACT = 2'd0,
      ST_PLAY    = 2'd1,
      ST_RESPAWN = 2'd2,
      ST_OVER    = 2'd3
   } state_t;

   localparam int          c_bcd_w     = 4;
   localparam logic [15:0] c_score_max = 16'h9999;

   // Ripple a +1 through four BCD digits; each digit wraps 9 -> 0 with carry.
   function automatic logic [15:0] bcd_inc(input logic [15:0] val);
      logic [15:0] res;
      logic        carry;
      res   = val;
      carry = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (carry) begin
            if (val[i*c_bcd_w +: c_bcd_w] == 4'd9) begin
               res[i*c_bcd_w +: c_bcd_w] = 4'd0;
            end else begin
               res[i*c_bcd_w +: c_bcd_w] = val[i*c_bcd_w +: c_bcd_w] + 4'd1;
               carry = 1'b0;
            end
         end
      end
      return res;
   endfunction

endpackage
`default_nettype wire

// File: rtl/game_flow_ctrl_bcd4_counter.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | bcd4_counter
// | 4-digit BCD counter with synchronous clear and saturation at 9999.
// | Revision: 1.0
// +-----------------------------------------------------------------------------
module bcd4_counter
   import game_flow_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   clr,
   input  logic                   inc,
   output logic [4*c_bcd_w-1:0]   count
);

   logic [4*c_bcd_w-1:0] r_count;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_count <= '0;
      end else if (clr) begin
         r_count <= '0;
      end else if (inc && (r_count != c_score_max)) begin
         r_count <= bcd_inc(r_count);
      end
   end

   assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/game_flow_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | game_flow_ctrl
// | Game phase sequencer: lives, BCD score, respawn/game-over frame timing.
// | Optional high score register enabled by GAME_FLOW_HISCORE_EN.
// | Revision: 1.0
// +-----------------------------------------------------------------------------
module game_flow_ctrl
   import game_flow_pkg::*;
#(
   parameter int LIVES          = 3,
   parameter int RESPAWN_FRAMES = 120,
   parameter int OVER_FRAMES    = 180
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        vs_neg,
   input  logic        start,
   input  logic        hit,
   input  logic        hited,
   output logic        play,
   output logic        invuln,
   output logic        game_over,
   output logic        frame_tick,
   output logic [1:0]  state,
   output logic [3:0]  lives,
   output logic [15:0] score,
   output logic [15:0] hiscore
);

   state_t      r_state;
   logic        r_start_q;
   logic [7:0]  r_timer;
   logic [3:0]  r_lives;
   logic        r_play;
   logic        r_invuln;
   logic        r_game_over;
   logic        r_frame_tick;
   logic        w_start_rise;
   logic        w_in_play;
   logic        w_new_game;
   logic        w_score_inc;
   logic [15:0] w_score;

   assign w_start_rise = start & ~r_start_q;
   assign w_in_play    = (r_state == ST_PLAY) || (r_state == ST_RESPAWN);
   assign w_new_game   = w_start_rise &&
                         ((r_state == ST_ATTRACT) || ((r_state == ST_OVER) && (r_timer == 8'd0)));
   assign w_score_inc  = hit && w_in_play;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= ST_ATTRACT;
         r_start_q    <= 1'b1;
         r_timer      <= 8'd0;
         r_lives      <= 4'd0;
         r_play       <= 1'b0;
         r_invuln     <= 1'b0;
         r_game_over  <= 1'b0;
         r_frame_tick <= 1'b0;
      end else begin
         r_start_q    <= start;
         r_frame_tick <= vs_neg && w_in_play;
         // Any reload below overrides this, so a fresh load is never decremented.
         if (vs_neg && (r_timer != 8'd0)) begin
            r_timer <= r_timer - 8'd1;
         end
         case (r_state)
            ST_ATTRACT, ST_OVER: begin
               if (w_new_game) begin
                  r_state     <= ST_PLAY;
                  r_lives     <= 4'(LIVES);
                  r_play      <= 1'b1;
                  r_game_over <= 1'b0;
               end
            end
            ST_PLAY: begin
               if (hited) begin
                  if (r_lives <= 4'd1) begin
                     r_state     <= ST_OVER;
                     r_lives     <= 4'd0;
                     r_timer     <= 8'(OVER_FRAMES);
                     r_play      <= 1'b0;
                     r_game_over <= 1'b1;
                  end else begin
                     r_state  <= ST_RESPAWN;
                     r_lives  <= r_lives - 4'd1;
                     r_timer  <= 8'(RESPAWN_FRAMES);
                     r_invuln <= 1'b1;
                  end
               end
            end
            ST_RESPAWN: begin
               if (vs_neg && (r_timer == 8'd1)) begin
                  r_state  <= ST_PLAY;
                  r_invuln <= 1'b0;
               end
            end
            default: r_state <= ST_ATTRACT;
         endcase
      end
   end

   bcd4_counter u_score (
      .clk   (clk),
      .rst   (rst),
      .clr   (w_new_game),
      .inc   (w_score_inc),
      .count (w_score)
   );

`ifdef GAME_FLOW_HISCORE_EN
   logic [15:0] r_hiscore;

   // Score is frozen while in OVER, so sampling it there captures the final score.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_hiscore <= 16'h0000;
      end else if ((r_state == ST_OVER) && (w_score > r_hiscore)) begin
         r_hiscore <= w_score;
      end
   end

   assign hiscore = r_hiscore;
`else
   assign hiscore = 16'h0000;
`endif

   assign state      = r_state;
   assign play       = r_play;
   assign invuln     = r_invuln;
   assign game_over  = r_game_over;
   assign frame_tick = r_frame_tick;
   assign lives      = r_lives;
   assign score      = w_score;

endmodule
`default_nettype wire

// File: tb/tb_game_flow_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | tb_game_flow_ctrl
// | Scoreboard bench: directed game scenarios plus random play vs. a model.
// | Revision: 1.0
// +-----------------------------------------------------------------------------
module tb_game_flow_ctrl;

   localparam int LIVES_P   = 3;
   localparam int RESPAWN_P = 120;
   localparam int OVER_P    = 180;
   localparam int M_ATTRACT = 0;
   localparam int M_PLAY    = 1;
   localparam int M_RESPAWN = 2;
   localparam int M_OVER    = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        vs_neg = 1'b0;
   logic        start = 1'b1;
   logic        hit = 1'b0;
   logic        hited = 1'b0;
   logic        play, invuln, game_over, frame_tick;
   logic [1:0]  state;
   logic [3:0]  lives;
   logic [15:0] score, hiscore;

   typedef struct packed {
      logic [1:0]  st;
      logic        ply;
      logic        inv;
      logic        gov;
      logic        tick;
      logic [3:0]  lv;
      logic [15:0] sc;
      logic [15:0] hi;
   } obs_t;

   obs_t exp_q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   // Reference model state, kept as plain integers.
   int m_mode, m_lives, m_score, m_hi, m_timer;
   bit m_prev_start;

   game_flow_ctrl #(
      .LIVES          (LIVES_P),
      .RESPAWN_FRAMES (RESPAWN_P),
      .OVER_FRAMES    (OVER_P)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .vs_neg     (vs_neg),
      .start      (start),
      .hit        (hit),
      .hited      (hited),
      .play       (play),
      .invuln     (invuln),
      .game_over  (game_over),
      .frame_tick (frame_tick),
      .state      (state),
      .lives      (lives),
      .score      (score),
      .hiscore    (hiscore)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] to_bcd(input int v);
      return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   function automatic obs_t model_obs(input bit tick);
      obs_t o;
      o.st   = 2'(m_mode);
      o.ply  = (m_mode == M_PLAY) || (m_mode == M_RESPAWN);
      o.inv  = (m_mode == M_RESPAWN);
      o.gov  = (m_mode == M_OVER);
      o.tick = tick;
      o.lv   = 4'(m_lives);
`ifdef GAME_FLOW_HISCORE_EN
      o.hi   = to_bcd(m_hi);
`else
      o.hi   = 16'h0000;
`endif
      o.sc   = to_bcd(m_score);
      return o;
   endfunction

   task automatic model_reset();
      m_mode = M_ATTRACT; m_lives = 0; m_score = 0; m_hi = 0; m_timer = 0;
      m_prev_start = 1'b1;
   endtask

   task automatic model_step(input bit vs, input bit st, input bit h, input bit hd);
      bit tick, rise, loaded;
      tick   = vs && ((m_mode == M_PLAY) || (m_mode == M_RESPAWN));
      rise   = st && !m_prev_start;
      m_prev_start = st;
      loaded = 1'b0;
      if ((m_mode == M_OVER) && (m_score > m_hi)) m_hi = m_score;
      case (m_mode)
         M_ATTRACT: if (rise) begin m_mode = M_PLAY; m_score = 0; m_lives = LIVES_P; end
         M_PLAY: begin
            if (h && m_score < 9999) m_score++;
            if (hd) begin
               loaded = 1'b1;
               if (m_lives <= 1) begin m_mode = M_OVER; m_lives = 0; m_timer = OVER_P; end
               else begin m_mode = M_RESPAWN; m_lives--; m_timer = RESPAWN_P; end
            end
         end
         M_RESPAWN: begin
            if (h && m_score < 9999) m_score++;
            if (vs && m_timer == 1) m_mode = M_PLAY;
         end
         default: if (rise && m_timer == 0) begin m_mode = M_PLAY; m_score = 0; m_lives = LIVES_P; end
      endcase
      if (!loaded && vs && m_timer > 0) m_timer--;
      exp_q.push_back(model_obs(tick));
   endtask

   task automatic compare(input obs_t act, input obs_t exp, input string tag);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         if (n_errors <= 30)
            $display("FAIL %s t=%0t actual st=%0d ply=%0b inv=%0b go=%0b tick=%0b lv=%0d sc=%h hi=%h required st=%0d ply=%0b inv=%0b go=%0b tick=%0b lv=%0d sc=%h hi=%h",
                     tag, $time, act.st, act.ply, act.inv, act.gov, act.tick, act.lv, act.sc, act.hi,
                     exp.st, exp.ply, exp.inv, exp.gov, exp.tick, exp.lv, exp.sc, exp.hi);
      end
   endtask

   function automatic obs_t dut_obs();
      return {state, play, invuln, game_over, frame_tick, lives, score, hiscore};
   endfunction

   // Monitor: every clock the DUT presents a registered result.
   initial begin
      obs_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            compare(dut_obs(), e, "cycle");
         end
      end
   end

   task automatic cyc(input bit vs, input bit st, input bit h, input bit hd);
      @(negedge clk);
      rst = 1'b1; vs_neg = vs; start = st; hit = h; hited = hd;
      model_step(vs, st, h, hd);
   endtask

   task automatic do_reset(input bit st);
      @(negedge clk);
      rst = 1'b0; vs_neg = 1'b0; start = st; hit = 1'b0; hited = 1'b0;
      #1;
      model_reset();
      compare(dut_obs(), model_obs(1'b0), "async_reset");
      exp_q.push_back(model_obs(1'b0));
   endtask

   task automatic frames(input int n);
      repeat (n) cyc(1'b1, 1'b1, 1'b0, 1'b0);
   endtask

   initial begin
      model_reset();
      do_reset(1'b1);
      do_reset(1'b1);
      // Key held through reset must not start a game.
      repeat (3) cyc(1'b0, 1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      repeat (12) cyc(1'b0, 1'b1, 1'b1, 1'b0);
      repeat (29) cyc(1'b0, 1'b1, 1'b1, 1'b0);
      cyc(1'b0, 1'b1, 1'b0, 1'b1);
      cyc(1'b0, 1'b1, 1'b0, 1'b1);
      frames(RESPAWN_P);
      cyc(1'b0, 1'b1, 1'b0, 1'b1);
      frames(RESPAWN_P);
      cyc(1'b0, 1'b1, 1'b1, 1'b1);
      frames(100);
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      frames(80);
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      repeat (17) cyc(1'b0, 1'b1, 1'b1, 1'b0);
      repeat (2) begin
         cyc(1'b0, 1'b1, 1'b0, 1'b1);
         frames(RESPAWN_P);
      end
      cyc(1'b0, 1'b1, 1'b0, 1'b1);
      repeat (3) cyc(1'b0, 1'b1, 1'b0, 1'b0);
      frames(OVER_P);
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      repeat (5) cyc(1'b0, 1'b1, 1'b1, 1'b0);
      do_reset(1'b1);
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      // Saturation run: a hit every cycle well past 9999.
      for (int i = 0; i < 10010; i++)
         cyc(($urandom_range(0, 2) == 0), 1'b1, 1'b1, 1'b0);
      do_reset(1'b0);
      begin
         bit st_lvl;
         st_lvl = 1'b0;
         for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 7) == 0) st_lvl = ~st_lvl;
            cyc(($urandom_range(0, 2) == 0), st_lvl,
                ($urandom_range(0, 3) == 0), ($urandom_range(0, 39) == 0));
         end
      end
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #2;
      n_checks++;
      if (exp_q.size() != 0) begin
         n_errors++;
         $display("FAIL drain actual %0d pending required 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
